// File: rtl/cb_multi_pkg.sv
// ---------------------------------------------------------------------------
// cb_multi_pkg
// Shared definitions for the cb_multi connection block: the loader state
// encoding and the helper functions that derive select widths, frame size
// and the bit offset of every routing field inside the configuration frame.
// The bitstream generator and the bench both compute frames from these
// same formulas.
// No ports (package).
// ---------------------------------------------------------------------------
package cb_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ID   = 2'd1,
      ST_LOAD = 2'd2
   } ld_state_t;

   // Track outputs choose between constant 0, both CLB output groups and the
   // same-side channel tracks.
   function automatic int trk_sel_width(input int chn_width, input int clb_owidth);
      return $clog2(chn_width + 2 * clb_owidth + 1);
   endfunction

   // CLB inputs choose between constant 0, both channel sides and the
   // opposite CLB's outputs.
   function automatic int clb_sel_width(input int chn_width, input int clb_owidth);
      return $clog2(clb_owidth + 2 * chn_width + 1);
   endfunction

   function automatic int cfg_size(input int clb_iwidth, input int clb_owidth,
                                   input int chn_width);
      return 2 * chn_width * (trk_sel_width(chn_width, clb_owidth) + 1) +
             2 * clb_iwidth * (clb_sel_width(chn_width, clb_owidth) + 1);
   endfunction

   // Track fields sit at the bottom of the frame: all of side 0, then side 1.
   function automatic int trk_field_off(input int side, input int idx,
                                        input int chn_width, input int clb_owidth);
      return (side * chn_width + idx) * (trk_sel_width(chn_width, clb_owidth) + 1);
   endfunction

   // CLB input fields follow the tracks: clb1_input first, clb0_input on top.
   function automatic int clb_field_off(input int clb, input int idx,
                                        input int clb_iwidth, input int chn_width,
                                        input int clb_owidth);
      int base;
      int fw;
      fw   = clb_sel_width(chn_width, clb_owidth) + 1;
      base = 2 * chn_width * (trk_sel_width(chn_width, clb_owidth) + 1);
      if (clb == 0) begin
         base = base + clb_iwidth * fw;
      end
      return base + idx * fw;
   endfunction

endpackage

// File: rtl/cb_multi_if.sv
// ---------------------------------------------------------------------------
// cb_multi_if
// Serial configuration bundle of one connection block.
//   cfg_in_start, cfg_bit_in : frame start marker and data from upstream
//   cfg_commit               : copy shadow configuration to active
//   cfg_out_start, cfg_bit_out : daisy-chain forward, one cycle later
//   cfg_done                 : one-cycle pulse, shadow fully loaded
// master = configuration source, slave = the connection block.
// ---------------------------------------------------------------------------
interface cb_multi_if;

   logic cfg_in_start;
   logic cfg_bit_in;
   logic cfg_commit;
   logic cfg_out_start;
   logic cfg_bit_out;
   logic cfg_done;

   modport master (
      output cfg_in_start, cfg_bit_in, cfg_commit,
      input  cfg_out_start, cfg_bit_out, cfg_done
   );

   modport slave (
      input  cfg_in_start, cfg_bit_in, cfg_commit,
      output cfg_out_start, cfg_bit_out, cfg_done
   );

endinterface

// File: rtl/MUXN.sv
// ---------------------------------------------------------------------------
// MUXN
// Generic single-bit N:1 multiplexer. Any select value at or beyond N
// returns 0, so unused encodings of a wide select are harmless.
//   din  : N candidate bits, index 0 is selected by sel=0
//   sel  : SW-bit select
//   dout : selected bit
// ---------------------------------------------------------------------------
module MUXN #(
   parameter int N  = 2,
   parameter int SW = 1
) (
   input  logic [N-1:0]  din,
   input  logic [SW-1:0] sel,
   output logic          dout
);

   // Compare against every legal index; nothing matches for out-of-range
   // selects and the default 0 survives.
   always_comb begin
      dout = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel == SW'(i)) begin
            dout = din[i];
         end
      end
   end

endmodule

// File: rtl/cb_cfg_loader.sv
// ---------------------------------------------------------------------------
// cb_cfg_loader
// Serial configuration loader for one connection block.
//   clk, crst : clock, synchronous active-low reset
//   cfg       : configuration bundle (slave side)
//   active    : committed configuration driving the routing muxes
// A frame is a start-marked ID (MSB first) followed by CFG_SIZE data bits.
// Only frames addressed to ID reach the shadow register; the shadow is
// copied to active on cfg_commit outside of a load.
// ---------------------------------------------------------------------------
module cb_cfg_loader
   import cb_multi_pkg::*;
#(
   parameter int CFG_SIZE = 332,
   parameter int ID_WIDTH = 3,
   parameter int ID       = 7
) (
   input  logic                clk,
   input  logic                crst,
   cb_multi_if.slave           cfg,
   output logic [CFG_SIZE-1:0] active
);

   localparam int                  CNT_W    = $clog2(CFG_SIZE + ID_WIDTH + 1);
   localparam logic [ID_WIDTH-1:0] MY_ID    = ID_WIDTH'(ID);
   localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(CFG_SIZE - 1);
   localparam logic [CNT_W-1:0]    ID_LEN   = CNT_W'(ID_WIDTH);

   ld_state_t           state;
   ld_state_t           state_n;
   logic [ID_WIDTH-1:0] id_buf;
   logic [ID_WIDTH-1:0] id_n;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_n;
   logic                shift_en;
   logic                done_n;
   logic [CFG_SIZE-1:0] shadow;

   // Forward path to the next block in the chain: a plain one-cycle delay
   // regardless of whether this block is addressed.
   always_ff @(posedge clk) begin
      if (!crst) begin
         cfg.cfg_out_start <= 1'b0;
         cfg.cfg_bit_out   <= 1'b0;
      end else begin
         cfg.cfg_out_start <= cfg.cfg_in_start;
         cfg.cfg_bit_out   <= cfg.cfg_bit_in;
      end
   end

   // Next-state logic. The counter is shared: it counts ID bits in ST_ID and
   // data bits in ST_LOAD. A start marker overrides everything, so a new
   // frame can abort a partial one; the shadow keeps its partial contents.
   // The ID decision is taken on the resolved next values so that the
   // start cycle itself counts as the first ID bit.
   always_comb begin
      state_n  = state;
      id_n     = id_buf;
      cnt_n    = cnt;
      shift_en = 1'b0;
      done_n   = 1'b0;
      case (state)
         ST_ID: begin
            id_n  = (id_buf << 1) | ID_WIDTH'(cfg.cfg_bit_in);
            cnt_n = cnt + CNT_W'(1);
         end
         ST_LOAD: begin
            shift_en = 1'b1;
            if (cnt == LAST_BIT) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
      if (cfg.cfg_in_start) begin
         state_n  = ST_ID;
         id_n     = ID_WIDTH'(cfg.cfg_bit_in);
         cnt_n    = CNT_W'(1);
         shift_en = 1'b0;
         done_n   = 1'b0;
      end
      if (state_n == ST_ID && cnt_n == ID_LEN) begin
         state_n = (id_n == MY_ID) ? ST_LOAD : ST_IDLE;
         cnt_n   = '0;
      end
   end

   // State, shadow and active registers. The first data bit of a frame
   // ends up at the shadow MSB. Commit is refused while loading so the
   // fabric never sees a half-shifted configuration; done is registered and
   // therefore appears in the cycle after the last data bit, when a
   // coincident commit already sees the complete shadow.
   always_ff @(posedge clk) begin
      if (!crst) begin
         state        <= ST_IDLE;
         id_buf       <= '0;
         cnt          <= '0;
         shadow       <= '0;
         active       <= '0;
         cfg.cfg_done <= 1'b0;
      end else begin
         state        <= state_n;
         id_buf       <= id_n;
         cnt          <= cnt_n;
         cfg.cfg_done <= done_n;
         if (shift_en) begin
            shadow <= {shadow[CFG_SIZE-2:0], cfg.cfg_bit_in};
         end
         if (cfg.cfg_commit && state != ST_LOAD) begin
            active <= shadow;
         end
      end
   end

endmodule

// File: rtl/cb_multi.sv
// ---------------------------------------------------------------------------
// cb_multi
// Configurable connection block between two channel sides and two CLBs.
//   clk, crst                : clock, synchronous active-low reset
//   clb0_output, clb1_output : outputs of the same-tile / adjacent CLB
//   clb0_input, clb1_input   : routed inputs to those CLBs
//   single0_in, single1_in   : incoming single tracks, side 0 / side 1
//   single0_out, single1_out : outgoing single tracks, side 0 / side 1
//   cfg                      : serial configuration bundle (slave)
// Every routed output has a {reg_en, sel} field in the active config; sel
// picks a source (0 = constant 0), reg_en adds one register stage.
// ---------------------------------------------------------------------------
module cb_multi
   import cb_multi_pkg::*;
#(
   parameter int CLB_IWIDTH = 10,
   parameter int CLB_OWIDTH = 4,
   parameter int CHN_WIDTH  = 16,
   parameter int ID_WIDTH   = 3,
   parameter int ID         = 7
) (
   input  logic                  clk,
   input  logic                  crst,
   input  logic [CLB_OWIDTH-1:0] clb0_output,
   input  logic [CLB_OWIDTH-1:0] clb1_output,
   output logic [CLB_IWIDTH-1:0] clb0_input,
   output logic [CLB_IWIDTH-1:0] clb1_input,
   input  logic [CHN_WIDTH-1:0]  single0_in,
   input  logic [CHN_WIDTH-1:0]  single1_in,
   output logic [CHN_WIDTH-1:0]  single0_out,
   output logic [CHN_WIDTH-1:0]  single1_out,
   cb_multi_if.slave             cfg
);

   localparam int SW       = trk_sel_width(CHN_WIDTH, CLB_OWIDTH);
   localparam int CW       = clb_sel_width(CHN_WIDTH, CLB_OWIDTH);
   localparam int CFG_SIZE = cfg_size(CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
   localparam int TRK_N    = 1 + 2 * CLB_OWIDTH + CHN_WIDTH;
   localparam int CLB_N    = 1 + 2 * CHN_WIDTH + CLB_OWIDTH;

   logic [CFG_SIZE-1:0]   active;
   logic [TRK_N-1:0]      trk0_src;
   logic [TRK_N-1:0]      trk1_src;
   logic [CLB_N-1:0]      cin0_src;
   logic [CLB_N-1:0]      cin1_src;
   logic [CHN_WIDTH-1:0]  trk0_mux;
   logic [CHN_WIDTH-1:0]  trk1_mux;
   logic [CHN_WIDTH-1:0]  trk0_q;
   logic [CHN_WIDTH-1:0]  trk1_q;
   logic [CHN_WIDTH-1:0]  trk0_en;
   logic [CHN_WIDTH-1:0]  trk1_en;
   logic [CLB_IWIDTH-1:0] cin0_mux;
   logic [CLB_IWIDTH-1:0] cin1_mux;
   logic [CLB_IWIDTH-1:0] cin0_q;
   logic [CLB_IWIDTH-1:0] cin1_q;
   logic [CLB_IWIDTH-1:0] cin0_en;
   logic [CLB_IWIDTH-1:0] cin1_en;

   cb_cfg_loader #(
      .CFG_SIZE (CFG_SIZE),
      .ID_WIDTH (ID_WIDTH),
      .ID       (ID)
   ) u_loader (
      .clk    (clk),
      .crst   (crst),
      .cfg    (cfg),
      .active (active)
   );

   // Source vectors are ordered so that the vector index equals the select
   // encoding; bit 0 is the constant-0 source.
   assign trk0_src = {single0_in, clb1_output, clb0_output, 1'b0};
   assign trk1_src = {single1_in, clb1_output, clb0_output, 1'b0};
   assign cin0_src = {clb1_output, single0_in, single1_in, 1'b0};
   assign cin1_src = {clb0_output, single0_in, single1_in, 1'b0};

   for (genvar k = 0; k < CHN_WIDTH; k++) begin : g_trk
      localparam int OFF0 = trk_field_off(0, k, CHN_WIDTH, CLB_OWIDTH);
      localparam int OFF1 = trk_field_off(1, k, CHN_WIDTH, CLB_OWIDTH);

      MUXN #(.N(TRK_N), .SW(SW)) u_mux0 (
         .din  (trk0_src),
         .sel  (active[OFF0 +: SW]),
         .dout (trk0_mux[k])
      );

      MUXN #(.N(TRK_N), .SW(SW)) u_mux1 (
         .din  (trk1_src),
         .sel  (active[OFF1 +: SW]),
         .dout (trk1_mux[k])
      );

      assign trk0_en[k] = active[OFF0 + SW];
      assign trk1_en[k] = active[OFF1 + SW];
   end

   for (genvar k = 0; k < CLB_IWIDTH; k++) begin : g_cin
      localparam int OFF0 = clb_field_off(0, k, CLB_IWIDTH, CHN_WIDTH, CLB_OWIDTH);
      localparam int OFF1 = clb_field_off(1, k, CLB_IWIDTH, CHN_WIDTH, CLB_OWIDTH);

      MUXN #(.N(CLB_N), .SW(CW)) u_mux0 (
         .din  (cin0_src),
         .sel  (active[OFF0 +: CW]),
         .dout (cin0_mux[k])
      );

      MUXN #(.N(CLB_N), .SW(CW)) u_mux1 (
         .din  (cin1_src),
         .sel  (active[OFF1 +: CW]),
         .dout (cin1_mux[k])
      );

      assign cin0_en[k] = active[OFF0 + CW];
      assign cin1_en[k] = active[OFF1 + CW];
   end

   // Optional output stage: every mux result is captured each cycle and
   // the per-output reg_en bit decides whether the registered copy is used.
   always_ff @(posedge clk) begin
      if (!crst) begin
         trk0_q <= '0;
         trk1_q <= '0;
         cin0_q <= '0;
         cin1_q <= '0;
      end else begin
         trk0_q <= trk0_mux;
         trk1_q <= trk1_mux;
         cin0_q <= cin0_mux;
         cin1_q <= cin1_mux;
      end
   end

   assign single0_out = (trk0_en & trk0_q) | (~trk0_en & trk0_mux);
   assign single1_out = (trk1_en & trk1_q) | (~trk1_en & trk1_mux);
   assign clb0_input  = (cin0_en & cin0_q) | (~cin0_en & cin0_mux);
   assign clb1_input  = (cin1_en & cin1_q) | (~cin1_en & cin1_mux);

endmodule

// File: tb/tb_cb_multi.sv
// ---------------------------------------------------------------------------
// tb_cb_multi
// Directed bench for cb_multi with default parameters. Frames are built
// from a local model of the field layout, shifted in serially, and the
// routed outputs are predicted from the committed frame and the current
// inputs. Forwarded chain bits and cfg_done are predicted per cycle through
// a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_cb_multi;

   localparam int FRAME_BITS = 332;

   logic        clk = 1'b0;
   logic        crst;
   logic [3:0]  clb0_output;
   logic [3:0]  clb1_output;
   logic [9:0]  clb0_input;
   logic [9:0]  clb1_input;
   logic [15:0] single0_in;
   logic [15:0] single1_in;
   logic [15:0] single0_out;
   logic [15:0] single1_out;

   cb_multi_if cfg_bus();

   cb_multi #(
      .CLB_IWIDTH (10),
      .CLB_OWIDTH (4),
      .CHN_WIDTH  (16),
      .ID_WIDTH   (3),
      .ID         (7)
   ) dut (
      .clk         (clk),
      .crst        (crst),
      .clb0_output (clb0_output),
      .clb1_output (clb1_output),
      .clb0_input  (clb0_input),
      .clb1_input  (clb1_input),
      .single0_in  (single0_in),
      .single1_in  (single1_in),
      .single0_out (single0_out),
      .single1_out (single1_out),
      .cfg         (cfg_bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic start;
      logic dbit;
      logic done;
   } fwd_t;

   fwd_t                  fwd_q[$];
   int                    total = 0;
   int                    bad   = 0;
   logic [FRAME_BITS-1:0] act_frame;
   logic [FRAME_BITS-1:0] new_frame;
   logic [FRAME_BITS-1:0] junk_frame;

   // Hand-derived layout: 6-bit track fields (5-bit sel), 7-bit CLB fields
   // (6-bit sel); tracks occupy bits 0..191, clb1 192..261, clb0 262..331.
   function automatic int tOff(input int side, input int k);
      return (side * 16 + k) * 6;
   endfunction

   function automatic int cOff(input int clb, input int k);
      return ((clb == 1) ? 192 : 262) + k * 7;
   endfunction

   task automatic setTrk(input int side, input int k, input logic reg_en, input int sel);
      new_frame[tOff(side, k) +: 5] = 5'(sel);
      new_frame[tOff(side, k) + 5]  = reg_en;
   endtask

   task automatic setClb(input int clb, input int k, input logic reg_en, input int sel);
      new_frame[cOff(clb, k) +: 6] = 6'(sel);
      new_frame[cOff(clb, k) + 6]  = reg_en;
   endtask

   function automatic logic trkExp(input int side, input int k);
      int          s;
      logic [15:0] same;
      s    = int'(act_frame[tOff(side, k) +: 5]);
      same = (side == 0) ? single0_in : single1_in;
      if (s >= 1 && s <= 4) return clb0_output[s-1];
      if (s >= 5 && s <= 8) return clb1_output[s-5];
      if (s >= 9 && s <= 24) return same[s-9];
      return 1'b0;
   endfunction

   function automatic logic clbExp(input int clb, input int k);
      int         s;
      logic [3:0] other;
      s     = int'(act_frame[cOff(clb, k) +: 6]);
      other = (clb == 0) ? clb1_output : clb0_output;
      if (s >= 1 && s <= 16) return single1_in[s-1];
      if (s >= 17 && s <= 32) return single0_in[s-17];
      if (s >= 33 && s <= 36) return other[s-33];
      return 1'b0;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic checkRouting(input string tag);
      logic [15:0] e_s0;
      logic [15:0] e_s1;
      logic [9:0]  e_c0;
      logic [9:0]  e_c1;
      for (int k = 0; k < 16; k++) begin
         e_s0[k] = trkExp(0, k);
         e_s1[k] = trkExp(1, k);
      end
      for (int k = 0; k < 10; k++) begin
         e_c0[k] = clbExp(0, k);
         e_c1[k] = clbExp(1, k);
      end
      checkOutput({tag, "/single0_out"}, 64'(single0_out), 64'(e_s0));
      checkOutput({tag, "/single1_out"}, 64'(single1_out), 64'(e_s1));
      checkOutput({tag, "/clb0_input"}, 64'(clb0_input), 64'(e_c0));
      checkOutput({tag, "/clb1_input"}, 64'(clb1_input), 64'(e_c1));
   endtask

   // One clock: drive config inputs, queue the expected forward/done values,
   // then compare them just after the edge.
   task automatic step(input logic st, input logic b, input logic cm, input logic exp_done);
      fwd_t e;
      cfg_bus.cfg_in_start = st;
      cfg_bus.cfg_bit_in   = b;
      cfg_bus.cfg_commit   = cm;
      if (crst === 1'b0) fwd_q.push_back('{start: 1'b0, dbit: 1'b0, done: 1'b0});
      else               fwd_q.push_back('{start: st, dbit: b, done: exp_done});
      @(posedge clk);
      #1;
      e = fwd_q.pop_front();
      checkOutput("fwd_done", 64'({cfg_bus.cfg_out_start, cfg_bus.cfg_bit_out, cfg_bus.cfg_done}),
                  64'({e.start, e.dbit, e.done}));
   endtask

   task automatic sendFrame(input logic [2:0] id, input logic [FRAME_BITS-1:0] f,
                            input int stop_at, input logic exp_done, input logic cm);
      for (int i = 0; i < 3; i++) step(i == 0, id[2-i], cm, 1'b0);
      for (int j = 0; j < FRAME_BITS; j++) begin
         if (j == stop_at) return;
         step(1'b0, f[FRAME_BITS-1-j], cm, exp_done && (j == FRAME_BITS - 1));
      end
   endtask

   task automatic randomInputs();
      clb0_output = 4'($urandom);
      clb1_output = 4'($urandom);
      single0_in  = 16'($urandom);
      single1_in  = 16'($urandom);
   endtask

   task automatic applyStimulus(input string tag);
      randomInputs();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checkRouting(tag);
   endtask

   task automatic randomFrame();
      new_frame = '0;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 16; k++)
            setTrk(s, k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 27)));
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 10; k++)
            setClb(c, k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
   endtask

   task automatic junkFrame();
      for (int i = 0; i < FRAME_BITS; i++) junk_frame[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t_list[9];
      int c_list[9];
      t_list = '{0, 1, 4, 5, 8, 9, 24, 25, 31};
      c_list = '{0, 1, 16, 17, 32, 33, 36, 37, 63};

      crst = 1'b0;
      cfg_bus.cfg_in_start = 1'b0;
      cfg_bus.cfg_bit_in   = 1'b0;
      cfg_bus.cfg_commit   = 1'b0;
      act_frame = '0;
      new_frame = '0;
      randomInputs();

      $display("[TB] reset and idle");
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      crst = 1'b1;
      checkOutput("rst/single0_out", 64'(single0_out), 64'd0);
      checkOutput("rst/single1_out", 64'(single1_out), 64'd0);
      checkOutput("rst/clb0_input", 64'(clb0_input), 64'd0);
      checkOutput("rst/clb1_input", 64'(clb1_input), 64'd0);
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 99) applyStimulus("idle");
         else step(1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("[TB] single0_out[0] from clb0_output[0], combinational then registered");
      clb0_output = 4'b0000;
      clb1_output = 4'b0000;
      single0_in  = 16'h0000;
      single1_in  = 16'h0000;
      new_frame   = '0;
      setTrk(0, 0, 1'b0, 1);
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      clb0_output = 4'b0001;
      #1;
      checkOutput("comb/single0_out", 64'(single0_out), 64'h0001);
      clb0_output = 4'b0000;
      new_frame   = '0;
      setTrk(0, 0, 1'b1, 1);
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      clb0_output = 4'b0001;
      #1;
      checkOutput("reg_hold/single0_out", 64'(single0_out), 64'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reg_rise/single0_out", 64'(single0_out), 64'h0001);

      $display("[TB] random configuration");
      randomFrame();
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      for (int i = 0; i < 3; i++) applyStimulus("rand_cfg");

      $display("[TB] select boundary configuration");
      new_frame = '0;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 16; k++) setTrk(s, k, 1'(k % 2), t_list[(k + s) % 9]);
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 10; k++) setClb(c, k, 1'((k + 1) % 2), c_list[(k + c) % 9]);
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      for (int i = 0; i < 4; i++) applyStimulus("boundary");

      $display("[TB] frame for another block");
      randomFrame();
      sendFrame(3'b101, new_frame, -1, 1'b0, 1'b0);
      checkRouting("other_id");
      step(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("other_id_commit");

      $display("[TB] commit held through load");
      randomFrame();
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b1);
      checkRouting("commit_in_load");
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      applyStimulus("commit_with_done");

      $display("[TB] restart in the middle of a load");
      junkFrame();
      randomFrame();
      sendFrame(3'b111, junk_frame, 100, 1'b0, 1'b0);
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      applyStimulus("restart");

      $display("[TB] reset in the middle of a load");
      junkFrame();
      sendFrame(3'b111, junk_frame, 200, 1'b0, 1'b0);
      crst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      crst = 1'b1;
      act_frame = '0;
      applyStimulus("load_reset");
      randomFrame();
      sendFrame(3'b111, new_frame, -1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      act_frame = new_frame;
      applyStimulus("after_reset");
      applyStimulus("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
